// File: rtl/exu_store_buf.sv
// exu_store_buf: store address/data formatting with an in-order store buffer draining to the MAU
module exu_store_buf #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  localparam int SW = XLEN / 8
) (
  input  logic                         hclk,
  input  logic                         hrst,
  input  logic                         dec_store_valid,
  output logic                         dec_store_ready,
  input  logic [1:0]                   dec_store_size,
  input  logic [11:0]                  dec_imm_type_s,
  input  logic [XLEN-1:0]              dec_rs1_val,
  input  logic [XLEN-1:0]              dec_rs2_val,
  input  logic                         flush,
  output logic                         mau_store_valid,
  input  logic                         mau_store_ready,
  output logic [XLEN-1:0]              mau_store_addr,
  output logic [XLEN-1:0]              mau_store_data,
  output logic [SW-1:0]                mau_store_strb,
  output logic                         exu_misalign,
  output logic [XLEN-1:0]              exu_misalign_addr,
  output logic [$clog2(DEPTH+1)-1:0]   sb_count
);
  localparam int OW = $clog2(SW);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [XLEN-1:0] ea, data, dmask;
  logic [SW-1:0]   strb, mask;
  logic [OW-1:0]   off;
  logic            mis, acc, push, pop;
  logic [PW-1:0]   wp, rp;
  logic [XLEN-1:0] addr_q [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [SW-1:0]   strb_q [DEPTH];
  assign ea = dec_rs1_val + {{(XLEN-12){dec_imm_type_s[11]}}, dec_imm_type_s};
  for (genvar i = 0; i < SW; i++) begin : g_dmask
    assign dmask[i*8 +: 8] = {8{mask[i]}};
  end
  // size decode, alignment check and lane placement of the incoming store
  always_comb begin
    off  = ea[OW-1:0];
    mask = dec_store_size == 2'd0 ? SW'(1) :
           dec_store_size == 2'd1 ? SW'(3) :
           dec_store_size == 2'd2 ? SW'(15) : {SW{1'b1}};
    mis  = (dec_store_size == 2'd1 && ea[0]) ||
           (dec_store_size == 2'd2 && ea[1:0] != 2'd0) ||
           (dec_store_size == 2'd3 && (XLEN == 32 || ea[2:0] != 3'd0));
    data = (dec_rs2_val & dmask) << {off, 3'b000};
    strb = mask << off;
  end
  assign dec_store_ready = !hrst && (sb_count < CW'(DEPTH));
  assign acc             = dec_store_valid && dec_store_ready && !flush;
  assign push            = acc && !mis;
  assign mau_store_valid = sb_count != '0;
  assign pop             = mau_store_valid && mau_store_ready && !hrst;
  assign mau_store_addr  = addr_q[rp];
  assign mau_store_data  = data_q[rp];
  assign mau_store_strb  = strb_q[rp];
  // entry storage; cleared on reset so the idle head reads as zero
  always_ff @(posedge hclk) begin
    if (hrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        strb_q[i] <= '0;
      end
    end else if (push) begin
      addr_q[wp] <= ea;
      data_q[wp] <= data;
      strb_q[wp] <= strb;
    end
  end
  // pointers and occupancy; flush wins over any same-cycle push
  always_ff @(posedge hclk) begin
    if (hrst || flush) begin
      wp       <= '0;
      rp       <= '0;
      sb_count <= '0;
    end else begin
      wp       <= push ? wp + 1'b1 : wp;
      rp       <= pop ? rp + 1'b1 : rp;
      sb_count <= sb_count + CW'(push) - CW'(pop);
    end
  end
  // one-cycle misalign pulse with sticky faulting address
  always_ff @(posedge hclk) begin
    if (hrst) begin
      exu_misalign      <= 1'b0;
      exu_misalign_addr <= '0;
    end else begin
      exu_misalign      <= acc && mis;
      exu_misalign_addr <= (acc && mis) ? ea : exu_misalign_addr;
    end
  end
endmodule

// File: tb/tb_exu_store_buf.sv
// tb_exu_store_buf: directed plus random checks of exu_store_buf against a queue-based model
module tb_exu_store_buf;
  typedef struct packed {logic [31:0] a; logic [31:0] d; logic [3:0] s;} ent_t;
  logic clk = 0, hrst = 1;
  logic valid = 0, flush = 0, mready = 0;
  logic [1:0] size = 0;
  logic [11:0] imm = 0;
  logic [31:0] rs1 = 0, rs2 = 0;
  logic ready, mvalid, mis;
  logic [31:0] maddr, mdata, mis_addr;
  logic [3:0] mstrb;
  logic [2:0] cnt;
  logic w_valid = 0, w_ready, w_mvalid, w_mis;
  logic [1:0] w_size = 0;
  logic [11:0] w_imm = 0;
  logic [63:0] w_rs1 = 0, w_rs2 = 0, w_maddr, w_mdata, w_mis_addr;
  logic [7:0] w_mstrb;
  logic [2:0] w_cnt;
  int checks = 0, failures = 0;
  ent_t q[$];
  logic em = 0;
  logic [31:0] ema = 0;
  always #5 clk = ~clk;
  exu_store_buf #(.XLEN(32), .DEPTH(4)) dut (
    .hclk(clk), .hrst(hrst), .dec_store_valid(valid), .dec_store_ready(ready),
    .dec_store_size(size), .dec_imm_type_s(imm), .dec_rs1_val(rs1), .dec_rs2_val(rs2),
    .flush(flush), .mau_store_valid(mvalid), .mau_store_ready(mready),
    .mau_store_addr(maddr), .mau_store_data(mdata), .mau_store_strb(mstrb),
    .exu_misalign(mis), .exu_misalign_addr(mis_addr), .sb_count(cnt));
  exu_store_buf #(.XLEN(64), .DEPTH(4)) dut64 (
    .hclk(clk), .hrst(hrst), .dec_store_valid(w_valid), .dec_store_ready(w_ready),
    .dec_store_size(w_size), .dec_imm_type_s(w_imm), .dec_rs1_val(w_rs1), .dec_rs2_val(w_rs2),
    .flush(1'b0), .mau_store_valid(w_mvalid), .mau_store_ready(1'b1),
    .mau_store_addr(w_maddr), .mau_store_data(w_mdata), .mau_store_strb(w_mstrb),
    .exu_misalign(w_mis), .exu_misalign_addr(w_mis_addr), .sb_count(w_cnt));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // byte-by-byte placement of the store, independent of any mask/shift formulation
  function automatic void ref_store(input logic [1:0] sz, input logic [11:0] im,
      input logic [31:0] a, input logic [31:0] d, output ent_t e, output logic m);
    int nb, off;
    nb = 1 << sz;
    e.a = a + {{20{im[11]}}, im};
    m = (sz == 2'd3) || (e.a % nb != 0);
    off = int'(e.a % 4);
    e.d = 0;
    e.s = 0;
    for (int b = 0; b < nb; b++)
      if (off + b < 4) begin
        e.d[(off+b)*8 +: 8] = d[b*8 +: 8];
        e.s[off+b] = 1'b1;
      end
  endfunction
  task automatic tick();
    ent_t e;
    logic m, acc, pop;
    ref_store(size, imm, rs1, rs2, e, m);
    acc = valid && !hrst && q.size() < 4 && !flush;
    pop = !hrst && q.size() != 0 && mready;
    @(posedge clk);
    if (hrst) begin
      q.delete();
      em = 0;
      ema = 0;
    end else begin
      if (pop) void'(q.pop_front());
      em = acc && m;
      if (em) ema = e.a;
      if (flush) q.delete();
      else if (acc && !m) q.push_back(e);
    end
    #1;
    chk("sb_count", 64'(cnt), 64'(q.size()));
    chk("mau_valid", 64'(mvalid), 64'(q.size() != 0));
    chk("dec_ready", 64'(ready), 64'(!hrst && q.size() < 4));
    chk("misalign", 64'(mis), 64'(em));
    chk("misalign_addr", 64'(mis_addr), 64'(ema));
    if (q.size() != 0) begin
      chk("head_addr", 64'(maddr), 64'(q[0].a));
      chk("head_data", 64'(mdata), 64'(q[0].d));
      chk("head_strb", 64'(mstrb), 64'(q[0].s));
    end
  endtask
  task automatic set_in(input logic v, input logic [1:0] sz, input logic [11:0] im,
      input logic [31:0] a, input logic [31:0] d, input logic f, input logic r);
    valid = v; size = sz; imm = im; rs1 = a; rs2 = d; flush = f; mready = r;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_addr", 64'(maddr), 64'h0);
    chk("rst_data", 64'(mdata), 64'h0);
    chk("rst_strb", 64'(mstrb), 64'h0);
    chk("rst64_ready", 64'(w_ready), 64'h0);
    hrst = 0;
    set_in(1, 2, 12'h004, 32'h1000, 32'hDEADBEEF, 0, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1);
    chk("word_valid", 64'(mvalid), 64'h1);
    chk("word_addr", 64'(maddr), 64'h1004);
    chk("word_data", 64'(mdata), 64'hDEADBEEF);
    chk("word_strb", 64'(mstrb), 64'hF);
    tick();
    chk("word_drained", 64'(cnt), 64'h0);
    set_in(1, 0, 12'h000, 32'h2003, 32'h000000AB, 0, 1);
    tick();
    chk("byte_data", 64'(mdata), 64'hAB000000);
    chk("byte_strb", 64'(mstrb), 64'h8);
    set_in(1, 1, 12'h000, 32'h2002, 32'h00001234, 0, 1);
    tick();
    chk("half_data", 64'(mdata), 64'h12340000);
    chk("half_strb", 64'(mstrb), 64'hC);
    set_in(1, 2, 12'hFF0, 32'h10, 32'h55AA55AA, 0, 1);
    tick();
    chk("negimm_addr", 64'(maddr), 64'h0);
    set_in(1, 1, 12'h000, 32'h101, 32'h1111, 0, 1);
    tick();
    chk("mis_pulse", 64'(mis), 64'h1);
    chk("mis_addr", 64'(mis_addr), 64'h101);
    chk("mis_no_enq", 64'(cnt), 64'h0);
    set_in(0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("mis_one_cycle", 64'(mis), 64'h0);
    for (int i = 0; i < 5; i++) begin
      set_in(1, 2, 12'(i * 4), 32'h3000, 32'hC0DE0000 + 32'(i), 0, 0);
      tick();
    end
    chk("full_ready", 64'(ready), 64'h0);
    chk("full_count", 64'(cnt), 64'h4);
    chk("full_head", 64'(maddr), 64'h3000);
    mready = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) valid = 0;
    end
    chk("full_drained", 64'(cnt), 64'h0);
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 12'(i), 32'h4000, 32'h77, 0, 0);
      tick();
    end
    set_in(1, 2, 12'h0, 32'h5000, 32'h99, 1, 0);
    tick();
    chk("flush_count", 64'(cnt), 64'h0);
    chk("flush_valid", 64'(mvalid), 64'h0);
    set_in(1, 3, 12'h0, 32'h40, 32'h1, 0, 1);
    tick();
    chk("sz3_mis", 64'(mis), 64'h1);
    chk("sz3_count", 64'(cnt), 64'h0);
    set_in(1, 2, 12'h0, 32'h6000, 32'h5, 0, 0);
    tick();
    tick();
    hrst = 1;
    tick();
    chk("midrst_count", 64'(cnt), 64'h0);
    chk("midrst_addr", 64'(maddr), 64'h0);
    hrst = 0;
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 12'($urandom),
             32'($urandom), 32'($urandom), $urandom_range(0, 29) == 0, $urandom_range(0, 2) != 0);
      hrst = $urandom_range(0, 99) == 0;
      tick();
    end
    hrst = 0;
    set_in(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) tick();
    w_valid = 1; w_size = 3; w_imm = 0; w_rs1 = 64'h8; w_rs2 = 64'h1122334455667788;
    @(posedge clk); #1;
    w_valid = 0;
    chk("dw_valid", 64'(w_mvalid), 64'h1);
    chk("dw_addr", w_maddr, 64'h8);
    chk("dw_data", w_mdata, 64'h1122334455667788);
    chk("dw_strb", 64'(w_mstrb), 64'hFF);
    @(posedge clk); #1;
    chk("dw_drained", 64'(w_cnt), 64'h0);
    w_valid = 1; w_size = 2; w_rs1 = 64'hC; w_rs2 = 64'hFFFFFFFF_AABBCCDD;
    @(posedge clk); #1;
    w_valid = 0;
    chk("w64_data", w_mdata, 64'hAABBCCDD_00000000);
    chk("w64_strb", 64'(w_mstrb), 64'hF0);
    w_valid = 1; w_size = 3; w_rs1 = 64'h4;
    @(posedge clk); #1;
    w_valid = 0;
    chk("dw_mis", 64'(w_mis), 64'h1);
    chk("dw_mis_addr", w_mis_addr, 64'h4);
    @(posedge clk); #1;
    chk("dw_mis_count", 64'(w_cnt), 64'h0);
    chk("dw_mis_clear", 64'(w_mis), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
